// File: rtl/risc_pkg.sv
// Shared decode definitions for the RISC core: instruction field layout,
// control-word widths, the default zero-extend opcode mask and the
// decoded-record layout carried through the decode buffer.
package risc_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SH_W   = 5;
    localparam int unsigned FN_W   = 6;
    localparam int unsigned CTRL_W = 12;
    localparam int unsigned IMM_W  = 16;

    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RD_LSB = 21;
    localparam int unsigned RS_LSB = 16;
    localparam int unsigned RT_LSB = 11;
    localparam int unsigned SH_LSB = 6;
    localparam int unsigned FN_LSB = 0;

    // Opcodes 0x0C..0x0E (logical immediates) zero-extend their immediate.
    localparam logic [63:0] DEF_ZEXT_MASK = 64'h0000_0000_0000_7000;

    // Width-independent part of a decoded entry; imm and pc depend on
    // XLEN/PC_W and are stored beside it in the stage.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [SH_W-1:0]   shift;
        logic              rtype;
    } dec_rec_t;

    // R-type instructions carry func in the low half of the control word.
    function automatic logic [CTRL_W-1:0] build_ctrl(input logic [OP_W-1:0] op,
                                                     input logic [FN_W-1:0] fn);
        build_ctrl = (op == '0) ? {op, fn} : {op, {FN_W{1'b0}}};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Handshake bus of the decode stage: fetch-side input channel and
// execute-side decoded-output channel. The stage uses the slave modport.
interface id_stage_if
    import risc_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [REG_W-1:0]  out_rd;
    logic [REG_W-1:0]  out_rs;
    logic [REG_W-1:0]  out_rt;
    logic [SH_W-1:0]   out_shift;
    logic [XLEN-1:0]   out_imm;
    logic [PC_W-1:0]   out_pc;
    logic              out_rtype;
    logic [LVL_W-1:0]  out_level;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_rd, out_rs, out_rt,
               out_shift, out_imm, out_pc, out_rtype, out_level
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_ctrl, out_rd, out_rs, out_rt,
               out_shift, out_imm, out_pc, out_rtype, out_level
    );

endinterface

// File: rtl/id_split.sv
// Combinational instruction split: field extraction, control-word build
// and XLEN immediate extension (sign or zero, chosen per opcode).
module id_split
    import risc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter logic [63:0] ZEXT_MASK = DEF_ZEXT_MASK
) (
    input  logic [INST_W-1:0] inst,
    output dec_rec_t          rec,
    output logic [XLEN-1:0]   imm
);

    logic [OP_W-1:0]  op;
    logic [FN_W-1:0]  fn;
    logic [IMM_W-1:0] imm16;

    assign op    = inst[OP_LSB +: OP_W];
    assign fn    = inst[FN_LSB +: FN_W];
    assign imm16 = inst[IMM_W-1:0];

    // Decode fields, control word and extended immediate.
    always_comb begin
        rec       = '0;
        rec.ctrl  = build_ctrl(op, fn);
        rec.rd    = inst[RD_LSB +: REG_W];
        rec.rs    = inst[RS_LSB +: REG_W];
        rec.rt    = inst[RT_LSB +: REG_W];
        rec.shift = inst[SH_LSB +: SH_W];
        rec.rtype = (op == '0);
        if (ZEXT_MASK[op])
            imm = XLEN'(imm16);
        else
            imm = XLEN'($signed(imm16));
    end

endmodule

// File: rtl/id_stage.sv
// Buffered decode stage: decodes on the input side and queues decoded
// records in a DEPTH-entry FIFO with valid/ready on both sides and flush.
module id_stage
    import risc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned DEPTH     = 2,
    parameter logic [63:0] ZEXT_MASK = DEF_ZEXT_MASK
) (
    input logic       clk,
    input logic       rst_n,
    input logic       flush,
    id_stage_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    dec_rec_t        dec_rec;
    logic [XLEN-1:0] dec_imm;

    dec_rec_t        rec_q [DEPTH];
    logic [XLEN-1:0] imm_q [DEPTH];
    logic [PC_W-1:0] pc_q  [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [LVL_W-1:0] level;
    logic             push, pop;

    id_split #(
        .XLEN      (XLEN),
        .ZEXT_MASK (ZEXT_MASK)
    ) u_split (
        .inst (bus.in_inst),
        .rec  (dec_rec),
        .imm  (dec_imm)
    );

    // Handshake and head-entry outputs; in_ready uses registered state only.
    always_comb begin
        bus.in_ready  = rst_n && (level < LVL_W'(DEPTH));
        bus.out_valid = (level != '0);
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
        bus.out_ctrl  = rec_q[rptr].ctrl;
        bus.out_rd    = rec_q[rptr].rd;
        bus.out_rs    = rec_q[rptr].rs;
        bus.out_rt    = rec_q[rptr].rt;
        bus.out_shift = rec_q[rptr].shift;
        bus.out_rtype = rec_q[rptr].rtype;
        bus.out_imm   = imm_q[rptr];
        bus.out_pc    = pc_q[rptr];
        bus.out_level = level;
    end

    // FIFO storage, pointers and level; reset and flush clear everything
    // and take priority over a same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rec_q[i] <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else begin
            if (push) begin
                rec_q[wptr] <= dec_rec;
                imm_q[wptr] <= dec_imm;
                pc_q[wptr]  <= bus.in_pc;
                wptr        <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode patterns, throughput,
// backpressure and flush, with a 64-bit-XLEN copy checked on extension.
module tb_id_stage;
    import risc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    id_stage_if #(.XLEN(32), .PC_W(32), .DEPTH(2)) bus ();
    id_stage_if #(.XLEN(64), .PC_W(32), .DEPTH(2)) bus64 ();

    id_stage #(.XLEN(32), .PC_W(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    id_stage #(.XLEN(64), .PC_W(32), .DEPTH(2)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus64)
    );

    assign bus64.in_valid  = bus.in_valid;
    assign bus64.in_inst   = bus.in_inst;
    assign bus64.in_pc     = bus.in_pc;
    assign bus64.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        offer(32'h0000_0020, 32'h0000_0100);

        // Reset held for two cycles with an instruction on offer.
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_level", 64'(bus.out_level), 64'd0);
        chk("rst_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("rst_imm", 64'(bus.out_imm), 64'd0);
        chk("rst_pc", 64'(bus.out_pc), 64'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // R-type decode, one-cycle latency.
        bus.out_ready = 1'b1;
        offer(32'h0000_0020, 32'h0000_0100);
        tick();
        bus.in_valid = 1'b0;
        chk("r_valid", 64'(bus.out_valid), 64'd1);
        chk("r_ctrl", 64'(bus.out_ctrl), 64'h020);
        chk("r_rtype", 64'(bus.out_rtype), 64'd1);
        chk("r_imm", 64'(bus.out_imm), 64'h20);
        chk("r_pc", 64'(bus.out_pc), 64'h100);
        tick();
        chk("r_drained", 64'(bus.out_level), 64'd0);

        // Sign-extended immediate, both XLEN variants.
        offer(32'h2022_FFFC, 32'h0000_0104);
        tick();
        bus.in_valid = 1'b0;
        chk("s_ctrl", 64'(bus.out_ctrl), 64'h200);
        chk("s_rd", 64'(bus.out_rd), 64'd1);
        chk("s_rs", 64'(bus.out_rs), 64'd2);
        chk("s_rt", 64'(bus.out_rt), 64'h1F);
        chk("s_rtype", 64'(bus.out_rtype), 64'd0);
        chk("s_imm", 64'(bus.out_imm), 64'h0000_0000_FFFF_FFFC);
        chk("s_imm64", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();

        // Zero-extended immediate (opcode 0x0D).
        offer(32'h3422_FFFC, 32'h0000_0108);
        tick();
        bus.in_valid = 1'b0;
        chk("z_ctrl", 64'(bus.out_ctrl), 64'h340);
        chk("z_imm", 64'(bus.out_imm), 64'h0000_FFFC);
        chk("z_imm64", bus64.out_imm, 64'h0000_0000_0000_FFFC);
        chk("z_shift", 64'(bus.out_shift), 64'h1F);
        tick();

        // Back-to-back throughput with the consumer always ready.
        offer(32'h0000_0024, 32'h0000_0200);
        tick();
        chk("t_pc0", 64'(bus.out_pc), 64'h200);
        offer(32'h0000_0025, 32'h0000_0204);
        tick();
        bus.in_valid = 1'b0;
        chk("t_pc1", 64'(bus.out_pc), 64'h204);
        chk("t_level", 64'(bus.out_level), 64'd1);
        tick();
        chk("t_drained", 64'(bus.out_valid), 64'd0);

        // Backpressure: A, B fill the buffer, C is held.
        bus.out_ready = 1'b0;
        offer(32'h0000_0021, 32'h0000_0300);
        tick();
        offer(32'h0000_0022, 32'h0000_0304);
        tick();
        offer(32'h0000_0023, 32'h0000_0308);
        chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("bp_level", 64'(bus.out_level), 64'd2);
        chk("bp_held_pc", 64'(bus.out_pc), 64'h300);
        chk("bp_held_ctrl", 64'(bus.out_ctrl), 64'h021);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_no_passthru", 64'(bus.in_ready), 64'd0);
        tick();
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        chk("bp_b_pc", 64'(bus.out_pc), 64'h304);
        chk("bp_lvl1", 64'(bus.out_level), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_c_pc", 64'(bus.out_pc), 64'h308);
        chk("bp_c_ctrl", 64'(bus.out_ctrl), 64'h023);
        chk("bp_c_lvl", 64'(bus.out_level), 64'd1);
        tick();
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // Flush with a full buffer and an instruction on offer.
        bus.out_ready = 1'b0;
        offer(32'h0000_0026, 32'h0000_0400);
        tick();
        offer(32'h0000_0027, 32'h0000_0404);
        tick();
        chk("f_full", 64'(bus.out_level), 64'd2);
        offer(32'h0000_0028, 32'h0000_0408);
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("f_level", 64'(bus.out_level), 64'd0);
        chk("f_valid", 64'(bus.out_valid), 64'd0);
        chk("f_cleared_pc", 64'(bus.out_pc), 64'd0);

        // Flush beats a same-cycle push and pop.
        bus.out_ready = 1'b1;
        offer(32'h0000_0029, 32'h0000_0500);
        tick();
        offer(32'h0000_002A, 32'h0000_0504);
        flush = 1'b1;
        chk("fp_ready", 64'(bus.in_ready), 64'd1);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fp_level", 64'(bus.out_level), 64'd0);
        chk("fp_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("fp_dropped_lvl", 64'(bus.out_level), 64'd0);
        chk("fp_dropped_pc", 64'(bus.out_pc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
